// File: rtl/dense_layer_ctrl.sv
// Dense-layer sequencer: streams (row, seg) operand pairs, folds the product results per row, writes one word per row.
// Latency: first write SEGS+MAC_LAT+1 cycles after start; one pair per cycle; no backpressure (ROMs/product unit fixed latency).
// Optional DENSE_RELU_EN clamps negative row results to zero on write.
module dense_layer_ctrl #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 25,
  parameter int SEGS    = 16,
  parameter int OUT_NUM = 84,
  parameter int MAC_LAT = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                rd_addr_out,
  input  logic [LANES*DATA_W-1:0]   rd_data_in,
  output logic [17:0]               kernel_addr_out,
  input  logic [LANES*DATA_W-1:0]   kernel_data_in,
  output logic [9:0]                bias_addr_out,
  input  logic [DATA_W-1:0]         bias_data_in,
  output logic [LANES*DATA_W-1:0]   vec_a_out,
  output logic [LANES*DATA_W-1:0]   vec_b_out,
  output logic [DATA_W-1:0]         bias_out,
  input  logic [DATA_W-1:0]         prod_in,
  input  logic [31:0]               wr_base,
  output logic [31:0]               wr_addr_out,
  output logic [DATA_W-1:0]         wr_data_out,
  output logic                      wr_en_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic       first;
    logic       last;
    logic [9:0] row;
  } tag_t;

  localparam logic [7:0]        SEG_LAST = 8'(SEGS - 1);
  localparam logic [9:0]        ROW_LAST = 10'(OUT_NUM - 1);
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic [7:0]        seg;
  logic [9:0]        row;
  logic [31:0]       base_q;
  logic [DATA_W-1:0] acc_q;
  logic              wr_final_q;
  tag_t              tag_q [MAC_LAT+1];
  tag_t              arr;
  logic              issue_last;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] res_w;
  logic [DATA_W-1:0] wr_val;

  assign issue_last = (state == S_ISSUE) && (seg == SEG_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (issue_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (wr_en_out && wr_final_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // seg runs fastest; counters park at zero outside ISSUE so addresses idle at 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg    <= '0;
      row    <= '0;
      base_q <= '0;
    end else begin
      if (state == S_IDLE && start) base_q <= wr_base;
      if (state == S_ISSUE) begin
        if (seg == SEG_LAST) begin
          seg <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 10'd1;
        end else begin
          seg <= seg + 8'd1;
        end
      end
    end
  end

  assign rd_addr_out     = seg;
  assign bias_addr_out   = row;
  assign kernel_addr_out = 18'(row) * 18'(SEGS) + 18'(seg);

  // stage 0 lines up with ROM data, stage MAC_LAT with prod_in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= MAC_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{vld: (state == S_ISSUE), first: (seg == 8'd0), last: (seg == SEG_LAST), row: row};
      for (int k = 1; k <= MAC_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign vec_a_out = kernel_data_in;
  assign vec_b_out = rd_data_in;
  assign bias_out  = (tag_q[0].vld && tag_q[0].first) ? bias_data_in : '0;
  assign arr       = tag_q[MAC_LAT];
  assign sum_w     = {acc_q[DATA_W-1], acc_q} + {prod_in[DATA_W-1], prod_in};

  always_comb begin
    res_w = prod_in;
    if (!arr.first) begin
      if (sum_w[DATA_W] != sum_w[DATA_W-1]) res_w = sum_w[DATA_W] ? SAT_MIN : SAT_MAX;
      else                                  res_w = sum_w[DATA_W-1:0];
    end
`ifdef DENSE_RELU_EN
    wr_val = res_w[DATA_W-1] ? '0 : res_w;
`else
    wr_val = res_w;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      wr_en_out   <= 1'b0;
      wr_final_q  <= 1'b0;
      wr_data_out <= '0;
      wr_addr_out <= '0;
    end else begin
      wr_en_out  <= 1'b0;
      wr_final_q <= 1'b0;
      if (arr.vld) begin
        acc_q <= res_w;
        if (arr.last) begin
          wr_en_out   <= 1'b1;
          wr_final_q  <= (arr.row == ROW_LAST);
          wr_data_out <= wr_val;
          wr_addr_out <= base_q + 32'(arr.row);
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Bench for dense_layer_ctrl: five parameterisations driven by ROM / product-unit models and a row-level result model.
module tb_dense_layer_ctrl;

  localparam int NI = 5;
  localparam int LW = 25 * 16;
  localparam int S_C [NI] = '{16, 1, 2, 16, 16};
  localparam int O_C [NI] = '{84, 3, 2, 84, 84};
  localparam int M_C [NI] = '{6, 2, 3, 1, 16};
`ifdef DENSE_RELU_EN
  localparam int L_NEG7 = 0;
  localparam int L_MIN  = 0;
`else
  localparam int L_NEG7 = -7;
  localparam int L_MIN  = -32768;
`endif

  logic clk;
  logic rst_n;
  logic          start    [NI];
  logic          busy     [NI];
  logic          done     [NI];
  logic [7:0]    rd_addr  [NI];
  logic [LW-1:0] rd_data  [NI];
  logic [17:0]   kaddr    [NI];
  logic [LW-1:0] kdata    [NI];
  logic [9:0]    baddr    [NI];
  logic [15:0]   bdata    [NI];
  logic [LW-1:0] vec_a    [NI];
  logic [LW-1:0] vec_b    [NI];
  logic [15:0]   bias_o   [NI];
  logic [15:0]   prod     [NI];
  logic [31:0]   base     [NI];
  logic [31:0]   wr_addr  [NI];
  logic [15:0]   wr_data  [NI];
  logic          wr_en    [NI];
  logic [15:0]   pipe     [NI][16];

  int pat [NI];
  int armed [NI];
  logic [31:0] exp_base [NI];
  int t0 [NI];
  int wcount [NI];
  int done_cnt [NI];
  int stray [NI];
  int last_wr [NI];
  int lit2 [3] = '{5, L_NEG7, 9};
  int lit3 [2] = '{32767, L_MIN};
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dense_layer_ctrl #(
      .DATA_W(16), .LANES(25), .SEGS(S_C[gi]), .OUT_NUM(O_C[gi]), .MAC_LAT(M_C[gi])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[gi]), .busy(busy[gi]), .done(done[gi]),
      .rd_addr_out(rd_addr[gi]), .rd_data_in(rd_data[gi]),
      .kernel_addr_out(kaddr[gi]), .kernel_data_in(kdata[gi]),
      .bias_addr_out(baddr[gi]), .bias_data_in(bdata[gi]),
      .vec_a_out(vec_a[gi]), .vec_b_out(vec_b[gi]), .bias_out(bias_o[gi]),
      .prod_in(prod[gi]), .wr_base(base[gi]),
      .wr_addr_out(wr_addr[gi]), .wr_data_out(wr_data[gi]), .wr_en_out(wr_en[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory contents per stimulus pattern
  function automatic int kval(int p, int r, int s, int l);
    case (p)
      0: return 1;
      1: return ((r + 2 * s + l) % 5) - 2;
      2: return (l == 0) ? ((r == 0) ? 5 : (r == 1) ? -7 : 9) : 0;
      3: return (l == 0) ? ((r == 0) ? 30000 : -30000) : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int xval(int p, int s, int l);
    case (p)
      0: return 1;
      1: return ((3 * s + l) % 7) - 3;
      default: return (l == 0) ? 1 : 0;
    endcase
  endfunction

  function automatic int bval(int p, int r);
    return (p == 1) ? r - 40 : 0;
  endfunction

  function automatic logic [LW-1:0] kword(int p, int sg, int a);
    logic [LW-1:0] w;
    int r;
    int s;
    w = '0;
    r = a / sg;
    s = a % sg;
    for (int l = 0; l < 25; l++) w[l*16 +: 16] = 16'(kval(p, r, s, l));
    return w;
  endfunction

  function automatic logic [LW-1:0] xword(int p, int s);
    logic [LW-1:0] w;
    w = '0;
    for (int l = 0; l < 25; l++) w[l*16 +: 16] = 16'(xval(p, s, l));
    return w;
  endfunction

  function automatic logic [15:0] dotp(logic [LW-1:0] a, logic [LW-1:0] b, logic [15:0] bs);
    int acc;
    acc = int'($signed(bs));
    for (int l = 0; l < 25; l++) acc += int'($signed(a[l*16 +: 16])) * int'($signed(b[l*16 +: 16]));
    return 16'(acc);
  endfunction

  // expected row result: saturating fold of per-segment products, bias only on segment 0
  function automatic int exp_val(int p, int sg, int r);
    int acc;
    int pr;
    logic signed [15:0] t;
    acc = 0;
    for (int s = 0; s < sg; s++) begin
      pr = (s == 0) ? bval(p, r) : 0;
      for (int l = 0; l < 25; l++) pr += kval(p, r, s, l) * xval(p, s, l);
      t = 16'(pr);
      pr = int'(t);
      if (s == 0) acc = pr;
      else begin
        acc += pr;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
      end
    end
`ifdef DENSE_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic chk(string name, int inst, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [u%0d]: got %0d, expected %0d (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  // ROMs (1-cycle) and product unit (MAC_LAT-cycle pipe)
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      kdata[i]   <= kword(pat[i], S_C[i], int'(kaddr[i]));
      rd_data[i] <= xword(pat[i], int'(rd_addr[i]));
      bdata[i]   <= 16'(bval(pat[i], int'(baddr[i])));
      for (int j = 15; j > 0; j--) pipe[i][j] <= pipe[i][j-1];
      pipe[i][0] <= dotp(vec_a[i], vec_b[i], bias_o[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) prod[i] = pipe[i][M_C[i]-1];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (armed[i] != 0 && rst_n && start[i] && !busy[i] && !done[i]) begin
        t0[i] = cyc + 1;
        wcount[i] = 0;
      end
      if (wr_en[i]) begin
        if (armed[i] == 0) stray[i]++;
        else begin
          if (wcount[i] == 0) chk("first_write_latency", i, cyc - t0[i], S_C[i] + M_C[i] + 1);
          chk("wr_addr", i, int'(wr_addr[i]), int'(exp_base[i]) + wcount[i]);
          chk("wr_data", i, int'($signed(wr_data[i])), exp_val(pat[i], S_C[i], wcount[i]));
          if (pat[i] == 0) chk("wr_data_400", i, int'($signed(wr_data[i])), 400);
          else if (pat[i] == 2 && wcount[i] < 3) chk("wr_data_seg1", i, int'($signed(wr_data[i])), lit2[wcount[i]]);
          else if (pat[i] == 3 && wcount[i] < 2) chk("wr_data_sat", i, int'($signed(wr_data[i])), lit3[wcount[i]]);
          wcount[i]++;
          last_wr[i] = cyc;
        end
      end
      if (done[i]) begin
        if (armed[i] == 0) stray[i]++;
        else begin
          done_cnt[i]++;
          chk("writes_at_done", i, wcount[i], O_C[i]);
          chk("done_after_last_write", i, cyc - last_wr[i], 1);
          chk("busy_low_in_done", i, int'(busy[i]), 0);
        end
      end
    end
  end

  task automatic check_idle(int i);
    int act;
    act = int'(busy[i]) + int'(done[i]) + int'(wr_en[i]) + int'(wr_addr[i] != 0) + int'(wr_data[i] != 0)
        + int'(rd_addr[i] != 0) + int'(kaddr[i] != 0) + int'(baddr[i] != 0);
    chk("reset_outputs_nonzero", i, act, 0);
  endtask

  task automatic launch(int i, int p, logic [31:0] b);
    pat[i] = p;
    base[i] = b;
    exp_base[i] = b;
    armed[i] = 1;
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    base[i] = b + 32'h100;
  endtask

  task automatic run_layer(int i, int p, logic [31:0] b);
    int d0;
    int k;
    d0 = done_cnt[i];
    launch(i, p, b);
    @(negedge clk);
    chk("busy_after_start", i, int'(busy[i]), 1);
    if (busy[i]) begin
      @(posedge clk); #1 start[i] = 1'b1;
      @(posedge clk); #1 start[i] = 1'b0;
    end
    k = 0;
    while (done_cnt[i] == d0 && k < 6000) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt[i] == d0) chk("done_timeout", i, 0, 1);
    repeat (3) @(posedge clk);
    #1 armed[i] = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("done_pulses", i, done_cnt[i] - d0, 1);
    chk("stray_activity", i, stray[i], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      base[i] = '0;
      pat[i] = 0;
      armed[i] = 0;
      exp_base[i] = '0;
      t0[i] = 0;
      wcount[i] = 0;
      done_cnt[i] = 0;
      stray[i] = 0;
      last_wr[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle(i);
    @(posedge clk); #1 rst_n = 1'b1;

    run_layer(0, 0, 32'd1000);
    run_layer(1, 2, 32'd200);
    run_layer(2, 3, 32'd300);
    run_layer(3, 0, 32'd400);
    run_layer(4, 0, 32'd500);

    // reset during issue cycle 50 of a layer
    launch(0, 1, 32'd2000);
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    armed[0] = 0;
    @(negedge clk);
    check_idle(0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("stray_after_reset", 0, stray[0], 0);
    chk("busy_after_reset", 0, int'(busy[0]), 0);

    run_layer(0, 1, 32'd3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_ctrl.md
DENSE_LAYER_CTRL -- requirements
Module: dense_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed fixed-point word width.
REQ-002 SHALL have parameter LANES, default 25, meaning words per segment.
REQ-003 SHALL have parameter SEGS, default 16, meaning segments per output row, range 1..256.
REQ-004 SHALL have parameter OUT_NUM, default 84, meaning output neurons, range 1..1024.
REQ-005 SHALL have parameter MAC_LAT, default 6, meaning external inner-product latency in cycles, range 1..16.
REQ-006 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: start  in  1  begin layer; busy  out  1  layer in progress; done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: rd_addr_out  out  8  input segment index; rd_data_in  in  LANES*DATA_W  input segment, valid 1 cycle after address.
REQ-010 SHALL have ports: kernel_addr_out  out  18  row*SEGS+seg; kernel_data_in  in  LANES*DATA_W  weights, 1-cycle ROM latency.
REQ-011 SHALL have ports: bias_addr_out  out  10  row index; bias_data_in  in  DATA_W  bias, 1-cycle ROM latency.
REQ-012 SHALL have ports: vec_a_out, vec_b_out  out  LANES*DATA_W  weights/inputs to product unit; bias_out  out  DATA_W  product-unit bias.
REQ-013 SHALL have ports: prod_in  in  DATA_W  product-unit result, MAC_LAT cycles after vec_a_out/vec_b_out.
REQ-014 SHALL have ports: wr_base  in  32  output base address; wr_addr_out  out  32; wr_data_out  out  DATA_W; wr_en_out  out  1.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE on start; ISSUE -> DRAIN after issuing pair (OUT_NUM-1, SEGS-1); DRAIN -> DONE when final write issues; DONE -> IDLE after one cycle.
REQ-016 SHALL ignore start outside IDLE; wr_base SHALL be sampled on the accepted start.
REQ-017 SHALL, in ISSUE, present one (row, seg) pair per cycle, seg fastest, rd_addr_out=seg, kernel_addr_out=row*SEGS+seg, bias_addr_out=row.
REQ-018 SHALL drive vec_a_out=kernel_data_in and vec_b_out=rd_data_in combinationally; bias_out=bias_data_in when the pair issued one cycle earlier had seg==0, else 0.
REQ-019 SHALL carry a valid/first/last/row tag through a 1+MAC_LAT delay line aligned to prod_in.
REQ-020 SHALL, on tagged arrival, load accumulator with prod_in when first, else add prod_in with signed saturation to DATA_W.
REQ-021 SHALL, on arrival tagged last, register wr_en_out=1, wr_data_out=result (REQ-028), wr_addr_out=wr_base+row in the next cycle; SEGS=1 SHALL be first and last together.
REQ-022 SHALL pulse done in DONE, one cycle after the final wr_en_out; busy=1 in ISSUE and DRAIN only.
REQ-023 SHALL produce exactly OUT_NUM writes per layer, rows ascending, no gaps; first write at cycle SEGS+MAC_LAT+1 after start accepted.
REQ-024 SHALL saturate at +2^(DATA_W-1)-1 and -2^(DATA_W-1); no wrap-around.

Reset
REQ-025 SHALL, on rst_n low at a clock edge, force IDLE, clear counters, accumulator, tag line; busy, done, wr_en_out=0; wr_addr_out, wr_data_out, rd/kernel/bias addresses=0.
REQ-026 SHALL, on reset mid-layer, discard all in-flight tags; no write SHALL occur after reset deasserts until a new start.

Configuration
REQ-027 SHALL support macro DENSE_RELU_EN.
REQ-028 SHALL, with DENSE_RELU_EN defined, write 0 for negative saturated results; without it, write the signed saturated result unchanged.

Verification
REQ-029 SHALL cover: defaults, all weights/inputs 1, bias 0, prod model=lane sum -> 84 writes of 400 (RELU on), addresses wr_base..wr_base+83, done once.
REQ-030 SHALL cover: SEGS=1, OUT_NUM=3, prod_in=5,-7,9 -> writes 5,0,9 with DENSE_RELU_EN; 5,-7,9 without.
REQ-031 SHALL cover: partial sums 30000+30000 (DATA_W=16) -> 32767; -30000+-30000 without RELU -> -32768.
REQ-032 SHALL cover: start pulsed while busy -> ignored, write count stays OUT_NUM, wr_base unchanged.
REQ-033 SHALL cover: rst_n low at issue cycle 50 for 1 cycle -> no wr_en_out or done until next start; next layer fully correct.
REQ-034 SHALL cover: MAC_LAT=1 and 16 -> first write at SEGS+MAC_LAT+1 cycles after start, same data as MAC_LAT=6.
